// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with optional burst locking of up to MAX_BURST beats per grant.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          full,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [NUM_REQ-1:0] READY_LSB = NUM_REQ'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    logic [ID_WIDTH-1:0] rr_ptr_r;
    logic [ID_WIDTH-1:0] owner_r;
    logic [CNT_W-1:0]    beat_cnt_r;

    logic [ID_WIDTH-1:0]   rr_sel_s;
    logic                  sel_valid_s;
    logic [ID_WIDTH-1:0]   sel_id_s;
    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];

    // Index arithmetic wraps at NUM_REQ, which need not be a power of two.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int step);
        int sum_v;
        sum_v = int'(base) + step;
        sum_v = (sum_v >= NUM_REQ) ? sum_v - NUM_REQ : sum_v;
        return ID_WIDTH'(sum_v);
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
        return wrap_add(idx, 1);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: scanning downward lets the candidate nearest rr_ptr win.
    always_comb begin
        rr_sel_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sel_s = req_valid[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : rr_sel_s;
        end
    end

    // Selection: free round-robin in IDLE, owner only while LOCKED.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = '0;
        case (state_r)
            IDLE: begin
                sel_valid_s = |req_valid;
                sel_id_s    = rr_sel_s;
            end
            LOCKED: begin
                sel_valid_s = req_valid[owner_r];
                sel_id_s    = owner_r;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_id_s    = '0;
            end
        endcase
    end

    // Handshake outputs; forced quiet while reset is asserted, even before any clock edge.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        w_en        = 1'b0;
        req_ready   = '0;
        data_in     = '0;
        if (rst_n && sel_valid_s) begin
            grant_valid = 1'b1;
            grant_id    = sel_id_s;
            data_in     = data_arr_s[sel_id_s];
            if (!full) begin
                w_en      = 1'b1;
                req_ready = READY_LSB << sel_id_s;
            end else begin
                w_en      = 1'b0;
                req_ready = '0;
            end
        end else begin
            grant_valid = 1'b0;
        end
    end

    // Arbitration state; a full FIFO holds everything because w_en stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (w_en) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr_r <= next_idx(sel_id_s);
                        end else begin
                            owner_r    <= sel_id_s;
                            beat_cnt_r <= CNT_W'(1);
                            state_r    <= LOCKED;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (!sel_valid_s) begin
                        rr_ptr_r   <= next_idx(owner_r);
                        beat_cnt_r <= '0;
                        state_r    <= IDLE;
                    end else if (w_en) begin
                        if (beat_cnt_r == CNT_W'(MAX_BURST - 1)) begin
                            rr_ptr_r   <= next_idx(owner_r);
                            beat_cnt_r <= '0;
                            state_r    <= IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers are word queues, expected writes are
// queued by the stimulus and popped by a negedge monitor whenever w_en is seen.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        w_en;
    logic [7:0]  data_in;
    logic        full;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic [7:0] pmem [4][32];
    int         head [4] = '{default: 0};
    int         tail [4] = '{default: 0};
    logic [3:0] en   = 4'b0000;
    logic [3:0] fire = 4'b0000;
    logic [9:0] exp_q [$];
    int         wen_cnt  = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         base;
    bit         full_force = 1'b0;
    bit         e2e        = 1'b0;
    bit         rd_en      = 1'b0;

    // Behavioural depth-8 synchronous FIFO for the end-to-end test.
    logic [9:0] fmem [8];
    logic [2:0] fwp   = 3'd0;
    logic [2:0] frp   = 3'd0;
    int         fcnt  = 0;
    bit         fwr   = 1'b0;
    bit         fpop  = 1'b0;
    logic [9:0] fword = 10'd0;
    int         e2e_seq [2] = '{default: 0};

    assign full = full_force || (fcnt == 8);

    fifo_wr_arbiter #(
        .DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .w_en(w_en), .data_in(data_in), .full(full),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Each producer presents its queue head while enabled and non-empty.
    always_comb begin
        req_valid = 4'b0000;
        req_data  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = pmem[i][head[i][4:0]];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) head[i] <= head[i] + 1;
        end
        if (fwr) begin
            fmem[fwp] <= fword;
            fwp       <= fwp + 3'd1;
        end
        if (fpop) frp <= frp + 3'd1;
        fcnt <= fcnt + int'(fwr) - int'(fpop);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    // Monitor: sample away from the active edge, score writes, model the FIFO.
    always @(negedge clk) begin : monitor
        logic [9:0] w;
        fire  <= req_valid & req_ready;
        fwr   <= e2e && w_en && !full;
        fword <= {grant_id, data_in};
        fpop  <= e2e && rd_en && (fcnt != 0);
        if (w_en) wen_cnt <= wen_cnt + 1;
        if (w_en && !e2e) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", {22'd0, grant_id, data_in}, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("wr_id", 32'(grant_id), 32'(w[9:8]));
                check("wr_data", 32'(data_in), 32'(w[7:0]));
                check("wr_ready", 32'(req_ready), 32'(4'b0001 << w[9:8]));
            end
        end
        if (e2e && full) check("e2e_write_while_full", 32'(w_en), 32'd0);
        if (e2e && rd_en && fcnt != 0) begin
            w = fmem[frp];
            check("e2e_tag", 32'(w[7:4]), 32'(w[9:8]));
            check("e2e_order", 32'(w[3:0]), 32'(e2e_seq[w[8]]));
            e2e_seq[w[8]] <= e2e_seq[w[8]] + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int p, input logic [7:0] d);
        pmem[p][tail[p][4:0]] = d;
        tail[p] = tail[p] + 1;
    endtask

    task automatic expect_wr(input int p, input logic [7:0] d);
        exp_q.push_back({p[1:0], d});
    endtask

    initial begin
        rst_n = 1'b0;
        // Fairness: every producer requesting, bursts of 4 in order 0..3 then 0 again.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                load(p, 8'(p*16 + k));
                expect_wr(p, 8'(p*16 + k));
            end
        end
        load(0, 8'h04);
        expect_wr(0, 8'h04);
        en = 4'b1111;
        step(3);
        @(negedge clk);
        check("reset_wen", 32'(w_en), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_grant", 32'({grant_valid, grant_id}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = wen_cnt;
        step(17);
        check("rr_no_bubbles", 32'(wen_cnt - base), 32'd17);
        step(3);
        check("rr_drain", 32'(exp_q.size()), 32'd0);

        // Single producer 2, six words: max-burst release re-grants it with no bubble.
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load(2, 8'hA0 + 8'(k));
            expect_wr(2, 8'hA0 + 8'(k));
        end
        en = 4'b0100;
        step(2);
        rst_n = 1'b1;
        base = wen_cnt;
        step(10);
        check("single_beats", 32'(wen_cnt - base), 32'd6);
        check("single_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure while producer 1 is locked at beat 2.
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load(1, 8'h50 + 8'(k));
            expect_wr(1, 8'h50 + 8'(k));
        end
        load(2, 8'h60);
        load(2, 8'h61);
        expect_wr(2, 8'h60);
        expect_wr(2, 8'h61);
        en = 4'b0110;
        step(2);
        rst_n = 1'b1;
        step(2);
        full_force = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_wen", 32'(w_en), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_grant", 32'({grant_valid, grant_id}), 32'b101);
            @(posedge clk);
            #1;
        end
        full_force = 1'b0;
        step(6);
        check("bp_drain", 32'(exp_q.size()), 32'd0);

        // Early release: owner 3 drops valid after one beat; pointer wraps to 0, not 1.
        rst_n = 1'b0;
        load(3, 8'h70);
        expect_wr(3, 8'h70);
        expect_wr(0, 8'h80);
        expect_wr(1, 8'h90);
        en = 4'b1000;
        step(2);
        rst_n = 1'b1;
        step(1);
        load(0, 8'h80);
        load(1, 8'h90);
        en = 4'b1011;
        @(negedge clk);
        check("early_bubble", 32'({grant_valid, w_en}), 32'd0);
        step(6);
        check("early_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with producer 2 at beat 3 abandons the burst.
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) load(2, 8'hC0 + 8'(k));
        for (int k = 0; k < 3; k++) expect_wr(2, 8'hC0 + 8'(k));
        en = 4'b0100;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("pre_reset_wen", 32'(w_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wen", 32'(w_en), 32'd0);
        check("async_ready", 32'(req_ready), 32'd0);
        check("async_grant", 32'({grant_valid, grant_id}), 32'd0);
        check("async_pending", 32'(exp_q.size()), 32'd0);
        load(0, 8'hD0);
        load(1, 8'hE0);
        load(3, 8'hF0);
        en = 4'b1111;
        expect_wr(0, 8'hD0);
        expect_wr(1, 8'hE0);
        for (int k = 3; k < 7; k++) expect_wr(2, 8'hC0 + 8'(k));
        expect_wr(3, 8'hF0);
        expect_wr(2, 8'hC7);
        step(2);
        rst_n = 1'b1;
        step(20);
        check("reset_drain", 32'(exp_q.size()), 32'd0);

        // End-to-end through a depth-8 FIFO; consumer starts late so full is exercised.
        rst_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            load(0, 8'(k));
            load(1, 8'h10 + 8'(k));
        end
        e2e = 1'b1;
        en = 4'b0000;
        step(2);
        rst_n = 1'b1;
        for (int c = 0; c < 140; c++) begin
            en = (c >= 100) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b0010);
            rd_en = (c >= 20) && (c % 2 == 1);
            step(1);
        end
        rd_en = 1'b0;
        step(2);
        check("e2e_count_p0", 32'(e2e_seq[0]), 32'd12);
        check("e2e_count_p1", 32'(e2e_seq[1]), 32'd12);
        check("e2e_fifo_empty", 32'(fcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
